// File: rtl/spram_pkg.sv
// Shared types and constants for the SP256K single-port RAM request controller.
package spram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP   = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } state_t;

    // MASKWE has one bit per nibble, bit 0 covering DI[3:0]
    localparam logic [3:0] MASK_W  = 4'b1111;
    localparam logic [3:0] MASK_LO = 4'b0011;
    localparam logic [3:0] MASK_HI = 4'b1100;
    localparam logic [3:0] MASK_RD = 4'b0000;

    localparam int WORDS = 16384;

endpackage

// File: rtl/spram_idle_tmr.sv
// Idle/wake timing for SPRAM standby: a saturating idle-cycle counter that
// requests standby, and a countdown that holds the port closed after wake-up.
// Only instantiated when SPRAM_STDBY_EN is defined.
module spram_idle_tmr #(
    parameter int IDLE_CYC = 64,
    parameter int WAKE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic wake_start,
    input  logic in_wake,
    output logic sleep_go,
    output logic wake_done
);

    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam int WW = $clog2(WAKE_CYC + 1);

    logic [IW-1:0] idle_cnt;
    logic [WW-1:0] wake_cnt;

    // Count consecutive idle cycles; any activity restarts the count
    always_ff @(posedge clk) begin
        if (rst || !idle) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(IDLE_CYC)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Load the wake delay on standby exit and run it down while waking
    always_ff @(posedge clk) begin
        if (rst) begin
            wake_cnt <= '0;
        end else if (wake_start) begin
            wake_cnt <= WW'(WAKE_CYC);
        end else if (in_wake && wake_cnt != '0) begin
            wake_cnt <= wake_cnt - 1'b1;
        end
    end

    // The cycle that brings the count to IDLE_CYC is the one that enters standby
    assign sleep_go  = idle && (idle_cnt == IW'(IDLE_CYC - 1));
    assign wake_done = in_wake && (wake_cnt <= WW'(1));

endmodule

// File: rtl/spram_ctrl.sv
// Request-side controller for one 16Kx16 SP256K SPRAM. Turns byte-addressed
// byte/word requests into CS/WE/MASKWE/AD/DI on the acceptance edge and returns
// the macro's registered read data on a valid/ready response channel.
// Optional standby power-down is enabled by defining SPRAM_STDBY_EN.
module spram_ctrl
    import spram_pkg::*;
#(
    parameter int AW       = 15,
    parameter int IDLE_CYC = 64,
    parameter int WAKE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [15:0]   rsp_rdata,
    output logic          misalign,
    output logic [AW-2:0] ram_ad,
    output logic [15:0]   ram_di,
    output logic [3:0]    ram_maskwe,
    output logic          ram_we,
    output logic          ram_cs,
    output logic          ram_stdby,
    input  logic [15:0]   ram_do
);

    state_t state;
    state_t state_nxt;
    logic   acc;
    logic   rd_acc;
    logic   lat_addr0;
    logic   lat_byte;

    assign acc    = req_valid & req_ready;
    assign rd_acc = acc & ~req_we;

`ifdef SPRAM_STDBY_EN
    logic sleep_go;
    logic wake_done;

    spram_idle_tmr #(
        .IDLE_CYC (IDLE_CYC),
        .WAKE_CYC (WAKE_CYC)
    ) u_idle_tmr (
        .clk        (clk),
        .rst        (rst),
        .idle       ((state == IDLE) && !req_valid),
        .wake_start ((state == SLEEP) && req_valid),
        .in_wake    (state == WAKE),
        .sleep_go   (sleep_go),
        .wake_done  (wake_done)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a read parks in RSP until the response is taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_acc) begin
                    state_nxt = RSP;
`ifdef SPRAM_STDBY_EN
                end else if (sleep_go) begin
                    state_nxt = SLEEP;
`endif
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt = rd_acc ? RSP : IDLE;
                end
            end
`ifdef SPRAM_STDBY_EN
            SLEEP: begin
                if (req_valid) begin
                    state_nxt = WAKE;
                end
            end
            WAKE: begin
                if (wake_done) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State outputs; in RSP a new request is taken only alongside the response
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_stdby = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            RSP: begin
                req_ready = rsp_ready;
                rsp_valid = 1'b1;
            end
`ifdef SPRAM_STDBY_EN
            SLEEP: ram_stdby = 1'b1;
`endif
            default: ;
        endcase
        if (rst) begin
            req_ready = 1'b0;
        end
    end

    // Macro drive straight from the accepted request, little-endian lanes
    always_comb begin
        ram_cs     = acc;
        ram_we     = acc & req_we;
        ram_ad     = acc ? req_addr[AW-1:1] : '0;
        ram_maskwe = MASK_RD;
        ram_di     = 16'h0000;
        if (acc && req_we) begin
            if (!req_byte) begin
                ram_maskwe = MASK_W;
                ram_di     = req_wdata;
            end else if (req_addr[0]) begin
                ram_maskwe = MASK_HI;
                ram_di     = {req_wdata[7:0], 8'h00};
            end else begin
                ram_maskwe = MASK_LO;
                ram_di     = {8'h00, req_wdata[7:0]};
            end
        end
    end

    // Remember lane selection of the read in flight
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            lat_addr0 <= req_addr[0];
            lat_byte  <= req_byte;
        end
    end

    // DO holds while CS is low, so the response is steered from it directly
    always_comb begin
        rsp_rdata = 16'h0000;
        if (state == RSP) begin
            if (!lat_byte) begin
                rsp_rdata = ram_do;
            end else begin
                rsp_rdata = {8'h00, lat_addr0 ? ram_do[15:8] : ram_do[7:0]};
            end
        end
    end

    // Sticky flag for word accesses on an odd byte address
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (acc && !req_byte && req_addr[0]) begin
            misalign <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spram_ctrl.sv
// Self-checking bench for spram_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a byte-array model.
module tb_spram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        misalign;
    logic [13:0] ram_ad;
    logic [15:0] ram_di;
    logic [3:0]  ram_maskwe;
    logic        ram_we;
    logic        ram_cs;
    logic        ram_stdby;
    logic [15:0] ram_do;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    spram_ctrl #(
        .AW       (15),
        .IDLE_CYC (4),
        .WAKE_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .misalign   (misalign),
        .ram_ad     (ram_ad),
        .ram_di     (ram_di),
        .ram_maskwe (ram_maskwe),
        .ram_we     (ram_we),
        .ram_cs     (ram_cs),
        .ram_stdby  (ram_stdby),
        .ram_do     (ram_do)
    );

    // SP256K behaviour: nibble-masked write, registered read, DO holds when CS=0
    logic [15:0] spram [16384];
    logic [15:0] mw;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                mw = spram[ram_ad];
                for (int k = 0; k < 4; k++)
                    if (ram_maskwe[k]) mw[k*4 +: 4] = ram_di[k*4 +: 4];
                spram[ram_ad] <= mw;
            end else begin
                ram_do <= spram[ram_ad];
            end
        end
    end

    // Reference model: the memory seen as plain bytes
    logic [7:0] ref_b [32768];

    function automatic logic [15:0] ref_read(input logic byt, input logic [14:0] a);
        if (byt) return {8'h00, ref_b[a]};
        return {ref_b[a | 15'h1], ref_b[a & ~15'h1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One request: handshake, check macro drive, model update, return read data
    task automatic do_op(input logic we, input logic byt, input logic [14:0] a,
                         input logic [15:0] wd, output logic [15:0] got);
        logic [3:0]  em;
        logic [15:0] ed;
        int n;
        got = 16'h0;
        if (!we)       begin em = 4'h0; ed = 16'h0; end
        else if (!byt) begin em = 4'hF; ed = wd; end
        else if (a[0]) begin em = 4'hC; ed = {wd[7:0], 8'h00}; end
        else           begin em = 4'h3; ed = {8'h00, wd[7:0]}; end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = a; req_wdata = wd;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        chk("ram_cs", {31'd0, ram_cs}, 32'd1);
        chk("ram_we", {31'd0, ram_we}, {31'd0, we});
        chk("ram_ad", {18'd0, ram_ad}, {18'd0, a[14:1]});
        chk("ram_maskwe", {28'd0, ram_maskwe}, {28'd0, em});
        if (we) chk("ram_di", {16'd0, ram_di}, {16'd0, ed});
        @(posedge clk);
        if (we) begin
            if (byt) ref_b[a] = wd[7:0];
            else begin
                ref_b[a & ~15'h1] = wd[7:0];
                ref_b[a | 15'h1]  = wd[15:8];
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (!we) begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            got = rsp_rdata;
        end
    endtask

    typedef struct {
        logic        we;
        logic        byt;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl [10];
    logic [15:0] got;
    logic [14:0] b2b_addr [4];
    logic        b2b_byte [4];
    logic [15:0] b2b_exp  [4];
    int          lows;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 15'h0010, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 15'h0010, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b0, 15'h0020, 16'h1234, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 15'h0021, 16'h005A, 16'h0000};
        tbl[4] = '{1'b0, 1'b0, 15'h0020, 16'h0000, 16'h5A34};
        tbl[5] = '{1'b0, 1'b1, 15'h0021, 16'h0000, 16'h005A};
        tbl[6] = '{1'b0, 1'b1, 15'h0020, 16'h0000, 16'h0034};
        tbl[7] = '{1'b1, 1'b0, 15'h0030, 16'hCCDD, 16'h0000};
        tbl[8] = '{1'b1, 1'b1, 15'h0030, 16'h11A7, 16'h0000};
        tbl[9] = '{1'b0, 1'b0, 15'h0030, 16'h0000, 16'hCCA7};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_ram_cs", {31'd0, ram_cs}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_stdby", {31'd0, ram_stdby}, 32'd0);
        chk("rst_ram_maskwe", {28'd0, ram_maskwe}, 32'd0);
        chk("rst_ram_ad", {18'd0, ram_ad}, 32'd0);
        chk("rst_ram_di", {16'd0, ram_di}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata, got);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), {16'd0, got}, {16'd0, tbl[i].exp});
        end

        // Four reads back to back, one response per cycle in order
        b2b_addr = '{15'h0010, 15'h0020, 15'h0030, 15'h0021};
        b2b_byte = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) b2b_exp[i] = ref_read(b2b_byte[i], b2b_addr[i]);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                req_valid = 1'b1; req_we = 1'b0; req_byte = b2b_byte[i]; req_addr = b2b_addr[i];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk($sformatf("b2b_rdata%0d", i - 1), {16'd0, rsp_rdata}, {16'd0, b2b_exp[i-1]});
            end
            if (i < 4) chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        end
        @(posedge clk);

        // Response stall: DO and data hold, port closed, next read waits
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 15'h0010;
        @(negedge clk);
        rsp_ready = 1'b0; req_addr = 15'h0020;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rdata", {16'd0, rsp_rdata}, {16'd0, ref_read(1'b0, 15'h0010)});
            chk("stall_ram_cs", {31'd0, ram_cs}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("release_rdata", {16'd0, rsp_rdata}, {16'd0, ref_read(1'b0, 15'h0020)});

        // Misaligned word read aligns down and sets the sticky flag
        do_op(1'b1, 1'b0, 15'h0002, 16'h7E81, got);
        chk("pre_misalign", {31'd0, misalign}, 32'd0);
        do_op(1'b0, 1'b0, 15'h0003, 16'h0000, got);
        chk("misalign_rdata", {16'd0, got}, 32'h7E81);
        chk("misalign_set", {31'd0, misalign}, 32'd1);

        // Randomized traffic on a small window
        for (int a = 0; a < 64; a += 2) do_op(1'b1, 1'b0, 15'(a), 16'($urandom), got);
        for (int i = 0; i < 150; i++) begin
            logic        we, byt;
            logic [14:0] a;
            logic [15:0] wd, exp;
            we  = 1'($urandom);
            byt = 1'($urandom);
            a   = 15'($urandom_range(0, 63));
            wd  = 16'($urandom);
            exp = ref_read(byt, a);
            do_op(we, byt, a, wd, got);
            if (!we) chk("rand_rdata", {16'd0, got}, {16'd0, exp});
        end
        chk("misalign_sticky", {31'd0, misalign}, 32'd1);

        // Reset while a response is stalled drops it
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 15'h0010;
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_cs", {31'd0, ram_cs}, 32'd0);
        chk("rst_rsp_idle", {31'd0, req_ready}, 32'd1);
        chk("rst_misalign_clr", {31'd0, misalign}, 32'd0);
        rsp_ready = 1'b1;

`ifdef SPRAM_STDBY_EN
        // Standby entry after idle cycles, wake delay, then a good read
        lows = 0;
        while (!ram_stdby && lows < 10) begin @(negedge clk); #1; lows++; end
        chk("stdby_enter", {31'd0, ram_stdby}, 32'd1);
        chk("stdby_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 15'h0010;
        @(negedge clk);
        #1;
        chk("stdby_exit", {31'd0, ram_stdby}, 32'd0);
        lows = 0;
        while (!req_ready && lows < 10) begin @(negedge clk); #1; lows++; end
        chk("wake_low_cycles", 32'(lows), 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("wake_rdata", {16'd0, rsp_rdata}, {16'd0, ref_read(1'b0, 15'h0010)});
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
